// File: rtl/xctcmsg_bus_arbiter.sv
// Round-robin bus arbiter for xctcmsg units: grants one sender, holds its message,
// then delivers it to the lowest-indexed port whose address matches, or counts a drop.
module xctcmsg_bus_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int DROP_COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*32-1:0]     port_address_i,
  input  logic [NUM_PORTS-1:0]        snd_val_i,
  output logic [NUM_PORTS-1:0]        snd_ack_o,
  input  logic [NUM_PORTS*32-1:0]     snd_dst_i,
  input  logic [NUM_PORTS*32-1:0]     snd_tag_i,
  input  logic [NUM_PORTS*64-1:0]     snd_msg_i,
  input  logic [NUM_PORTS-1:0]        rcv_rdy_i,
  output logic [NUM_PORTS-1:0]        rcv_val_o,
  output logic [31:0]                 rcv_src_o,
  output logic [31:0]                 rcv_tag_o,
  output logic [63:0]                 rcv_msg_o,
  output logic                        busy_o,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count_o,
  output logic                        dbg_state_o
);

  localparam int IW = $clog2(NUM_PORTS);

  // Handshake: a sender holds snd_val_i with stable data until snd_ack_o pulses for
  // one cycle; a delivery is held on rcv_val_o until the target's rcv_rdy_i is high.
  typedef enum logic {ST_IDLE = 1'b0, ST_DELIVER = 1'b1} state_t;

  state_t                      r_state;
  logic [IW-1:0]               r_last_grant;
  logic [31:0]                 r_src;
  logic [31:0]                 r_dst;
  logic [31:0]                 r_tag;
  logic [63:0]                 r_msg;
  logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

  logic          w_grant_found;
  logic [IW-1:0] w_grant;
  logic          w_target_found;
  logic [IW-1:0] w_target;
  logic          w_accept;

  always_comb begin
    w_grant_found = 1'b0;
    w_grant       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!w_grant_found && snd_val_i[(int'(r_last_grant) + k) % NUM_PORTS]) begin
        w_grant_found = 1'b1;
        w_grant       = IW'((int'(r_last_grant) + k) % NUM_PORTS);
      end
    end
  end

  // Scan downward so the lowest matching index is the one that sticks.
  always_comb begin
    w_target_found = 1'b0;
    w_target       = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_address_i[i*32 +: 32] == r_dst) begin
        w_target_found = 1'b1;
        w_target       = IW'(i);
      end
    end
  end

  assign w_accept = !rst && (r_state == ST_IDLE) && w_grant_found;

  always_comb begin
    snd_ack_o = '0;
    rcv_val_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      snd_ack_o[i] = w_accept && (w_grant == IW'(i));
      rcv_val_o[i] = !rst && (r_state == ST_DELIVER) && w_target_found && (w_target == IW'(i));
    end
  end

  assign rcv_src_o    = r_src;
  assign rcv_tag_o    = r_tag;
  assign rcv_msg_o    = r_msg;
  assign busy_o       = !rst && (r_state == ST_DELIVER);
  assign drop_count_o = rst ? '0 : r_drop_count;
  assign dbg_state_o  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= IW'(NUM_PORTS - 1);
      r_src        <= '0;
      r_dst        <= '0;
      r_tag        <= '0;
      r_msg        <= '0;
      r_drop_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_found) begin
            r_src        <= port_address_i[int'(w_grant)*32 +: 32];
            r_dst        <= snd_dst_i[int'(w_grant)*32 +: 32];
            r_tag        <= snd_tag_i[int'(w_grant)*32 +: 32];
            r_msg        <= snd_msg_i[int'(w_grant)*64 +: 64];
            r_last_grant <= w_grant;
            r_state      <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (!w_target_found) begin
            if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
            r_state <= ST_IDLE;
          end else if (rcv_rdy_i[w_target]) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xctcmsg_bus_arbiter.sv
// Directed bench for xctcmsg_bus_arbiter: a per-cycle reference model plus
// hand-computed checkpoints for transfer, fairness, back-pressure, drop and reset.
module tb_xctcmsg_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*32-1:0] addr;
  logic [N-1:0]    val = '0;
  logic [N-1:0]    ack;
  logic [N*32-1:0] dst = '0;
  logic [N*32-1:0] tag = '0;
  logic [N*64-1:0] msg = '0;
  logic [N-1:0]    rdy = '0;
  logic [N-1:0]    rval;
  logic [31:0]     rsrc, rtag;
  logic [63:0]     rmsg;
  logic            busy;
  logic [DW-1:0]   drop;
  logic            dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int rep [N];

  xctcmsg_bus_arbiter #(.NUM_PORTS(N), .DROP_COUNT_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .port_address_i(addr),
    .snd_val_i(val), .snd_ack_o(ack), .snd_dst_i(dst), .snd_tag_i(tag), .snd_msg_i(msg),
    .rcv_rdy_i(rdy), .rcv_val_o(rval), .rcv_src_o(rsrc), .rcv_tag_o(rtag), .rcv_msg_o(rmsg),
    .busy_o(busy), .drop_count_o(drop), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] a_of(int i);
    return 32'hA000_0000 + 32'(i * 16);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic send(int p, logic [31:0] d, logic [31:0] tg, logic [63:0] m, int r);
    dst[p*32 +: 32] = d;
    tag[p*32 +: 32] = tg;
    msg[p*64 +: 64] = m;
    rep[p]          = r;
    val[p]          = 1'b1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      at_neg();
      if (val == '0 && !busy) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_idle: val=%b busy=%b, required all senders served", val, busy);
  endtask

  // sender behaviour: after an ack either re-offer a fresh message or withdraw
  logic [N-1:0] ack_seen = '0;
  always @(negedge clk) ack_seen = ack;
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < N; p++) begin
      if (ack_seen[p]) begin
        if (rep[p] > 0) begin
          rep[p]--;
          msg[p*64 +: 64] = msg[p*64 +: 64] + 64'd1;
        end else begin
          val[p] = 1'b0;
        end
      end
    end
  end

  // scoreboard: reference model of the arbiter, compared every cycle
  bit              m_busy;
  int              m_last;
  logic [31:0]     m_src, m_dst, m_tag;
  logic [63:0]     m_msg;
  logic [DW-1:0]   m_drop;
  bit              m_on = 0;
  logic [N-1:0]    p_val = '0, p_ack = '0;
  logic [N*32-1:0] p_dst, p_tag;
  logic [N*64-1:0] p_msg;

  always @(negedge clk) begin : model
    logic [N-1:0]  e_ack, e_rval;
    logic          e_busy;
    logic [DW-1:0] e_drop;
    int g, t;
    e_ack  = '0;
    e_rval = '0;
    e_busy = 1'b0;
    e_drop = '0;
    if (rst) begin
      m_busy = 0; m_last = N - 1; m_drop = '0;
      m_src = '0; m_dst = '0; m_tag = '0; m_msg = '0;
      m_on = 1;
    end else if (m_on) begin
      e_drop = m_drop;
      if (!m_busy) begin
        g = -1;
        for (int k = 1; k <= N; k++)
          if (g < 0 && val[(m_last + k) % N]) g = (m_last + k) % N;
        if (g >= 0) begin
          e_ack[g] = 1'b1;
          m_src  = addr[g*32 +: 32];
          m_dst  = dst[g*32 +: 32];
          m_tag  = tag[g*32 +: 32];
          m_msg  = msg[g*64 +: 64];
          m_last = g;
          m_busy = 1;
        end
      end else begin
        e_busy = 1'b1;
        t = -1;
        for (int i = 0; i < N; i++)
          if (t < 0 && addr[i*32 +: 32] == m_dst) t = i;
        if (t >= 0) begin
          e_rval[t] = 1'b1;
          chk("model_src", rsrc, m_src);
          chk("model_tag", rtag, m_tag);
          chk("model_msg", rmsg, m_msg);
          if (rdy[t]) m_busy = 0;
        end else begin
          if (m_drop != '1) m_drop = m_drop + 1'b1;
          m_busy = 0;
        end
      end
    end
    if (m_on) begin
      chk("model_ack", ack, e_ack);
      chk("model_rval", rval, e_rval);
      chk("model_busy", busy, e_busy);
      chk("model_drop", drop, e_drop);
      for (int p = 0; p < N; p++) begin
        if (!rst && p_val[p] && !p_ack[p] &&
            (!val[p] || dst[p*32 +: 32] != p_dst[p*32 +: 32] ||
             tag[p*32 +: 32] != p_tag[p*32 +: 32] || msg[p*64 +: 64] != p_msg[p*64 +: 64])) begin
          n_errors++;
          $display("FAIL sender_hold: port %0d changed before ack", p);
        end
      end
    end
    p_val = val; p_ack = ack; p_dst = dst; p_tag = tag; p_msg = msg;
  end

  logic [3:0] fair_exp [10] = '{4'd1, 4'd0, 4'd2, 4'd0, 4'd4, 4'd0, 4'd8, 4'd0, 4'd1, 4'd0};

  initial begin
    for (int i = 0; i < N; i++) begin
      addr[i*32 +: 32] = a_of(i);
      rep[i] = 0;
    end
    // reset state
    repeat (3) cyc();
    at_neg();
    chk("rst_ack", ack, 4'b0); chk("rst_rval", rval, 4'b0);
    chk("rst_busy", busy, 1'b0); chk("rst_drop", drop, 16'h0);
    cyc();
    rst = 1'b0;
    at_neg();
    chk("post_rst_busy", busy, 1'b0); chk("post_rst_drop", drop, 16'h0);

    // single transfer 1 -> 2
    do_reset();
    rdy = 4'b0100;
    send(1, a_of(2), 32'h5, 64'hDEADBEEF, 0);
    at_neg(); chk("t1_ack", ack, 4'b0010);
    cyc(); at_neg();
    chk("t1_rval", rval, 4'b0100); chk("t1_src", rsrc, a_of(1));
    chk("t1_tag", rtag, 32'h5); chk("t1_msg", rmsg, 64'hDEADBEEF); chk("t1_busy", busy, 1'b1);
    cyc(); at_neg();
    chk("t1_idle_busy", busy, 1'b0); chk("t1_idle_rval", rval, 4'b0);
    wait_idle();

    // fairness: all ports request continuously
    do_reset();
    rdy = 4'b1111;
    for (int p = 0; p < N; p++) send(p, a_of((p + 1) % N), 32'(p), 64'(p * 100), 1);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc();
      at_neg();
      chk($sformatf("fair_ack_c%0d", c), ack, fair_exp[c]);
    end
    wait_idle();

    // back-pressure on port 3, other ready bits high but ignored
    do_reset();
    rdy = 4'b0111;
    send(0, a_of(3), 32'h33, 64'h1122334455667788, 0);
    send(1, a_of(2), 32'h44, 64'h99, 0);
    at_neg(); chk("bp_ack", ack, 4'b0001);
    for (int c = 1; c <= 5; c++) begin
      cyc(); at_neg();
      chk($sformatf("bp_rval_c%0d", c), rval, 4'b1000);
      chk($sformatf("bp_busy_c%0d", c), busy, 1'b1);
      chk($sformatf("bp_noack_c%0d", c), ack, 4'b0);
      chk($sformatf("bp_msg_c%0d", c), rmsg, 64'h1122334455667788);
    end
    cyc(); rdy = 4'b1111; at_neg();
    chk("bp_deliver_rval", rval, 4'b1000);
    cyc(); at_neg();
    chk("bp_next_ack", ack, 4'b0010); chk("bp_next_rval", rval, 4'b0);
    cyc(); at_neg();
    chk("bp_second_rval", rval, 4'b0100);
    wait_idle();

    // drop and saturation
    do_reset();
    rdy = 4'b1111;
    send(2, 32'h1234_5678, 32'h1, 64'h2, 0);
    at_neg(); chk("drop_ack", ack, 4'b0100); chk("drop_cnt0", drop, 16'h0);
    cyc(); at_neg(); chk("drop_rval", rval, 4'b0); chk("drop_busy", busy, 1'b1);
    cyc(); at_neg(); chk("drop_cnt1", drop, 16'h1); chk("drop_idle", busy, 1'b0);
    cyc();
    force dut.r_drop_count = 16'hFFFE;
    m_drop = 16'hFFFE;
    #1;
    release dut.r_drop_count;
    send(0, 32'h0BAD_0000, 32'h3, 64'h4, 1);
    at_neg(); chk("sat_cnt_a", drop, 16'hFFFE); chk("sat_ack_a", ack, 4'b0001);
    cyc(); at_neg(); chk("sat_rval", rval, 4'b0);
    cyc(); at_neg(); chk("sat_cnt_b", drop, 16'hFFFF); chk("sat_ack_b", ack, 4'b0001);
    cyc(); at_neg();
    cyc(); at_neg(); chk("sat_cnt_c", drop, 16'hFFFF);
    wait_idle();
    do_reset();
    at_neg(); chk("drop_cleared", drop, 16'h0);

    // reset in the middle of a held delivery
    do_reset();
    rdy = 4'b0000;
    send(1, a_of(3), 32'h66, 64'h6, 0);
    at_neg(); chk("mr_ack", ack, 4'b0010);
    cyc(); at_neg(); chk("mr_rval", rval, 4'b1000); chk("mr_busy", busy, 1'b1);
    cyc();
    rst = 1'b1;
    send(2, a_of(0), 32'h77, 64'h7, 0);
    at_neg();
    chk("mr_in_rst_ack", ack, 4'b0); chk("mr_in_rst_rval", rval, 4'b0); chk("mr_in_rst_busy", busy, 1'b0);
    cyc();
    rst = 1'b0;
    rdy = 4'b1111;
    send(0, a_of(1), 32'h88, 64'h8, 0);
    at_neg();
    chk("mr_after_rval", rval, 4'b0); chk("mr_after_busy", busy, 1'b0);
    chk("mr_first_grant", ack, 4'b0001);
    wait_idle();

    // duplicate addresses: ports 1 and 3 share a_of(1)
    do_reset();
    addr[3*32 +: 32] = a_of(1);
    rdy = 4'b1010;
    send(0, a_of(1), 32'h5, 64'h6, 0);
    at_neg(); chk("dup_ack", ack, 4'b0001);
    cyc(); at_neg(); chk("dup_rval", rval, 4'b0010);
    wait_idle();
    cyc();
    addr[3*32 +: 32] = a_of(3);

    // self-delivery
    rdy = 4'b1111;
    send(2, a_of(2), 32'h9, 64'hA, 0);
    at_neg(); chk("self_ack", ack, 4'b0100);
    cyc(); at_neg(); chk("self_rval", rval, 4'b0100); chk("self_src", rsrc, a_of(2));
    wait_idle();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xctcmsg_bus_arbiter.md
XCTCMSG_BUS_ARBITER -- requirements
Module: xctcmsg_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of attached xctcmsg units (2..16).
REQ-002 SHALL have parameter DROP_COUNT_WIDTH, default 16: width of the drop counter.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port port_address_i, input, NUM_PORTS*32: bus address of each port; slice i belongs to port i; held static.
REQ-006 SHALL have port snd_val_i, input, NUM_PORTS: per-port send request, driven by the unit's bus_val_o.
REQ-007 SHALL have port snd_ack_o, output, NUM_PORTS: per-port one-cycle acceptance pulse, driving the unit's bus_ack_i.
REQ-008 SHALL have ports snd_dst_i, snd_tag_i and snd_msg_i, input, NUM_PORTS*32, NUM_PORTS*32 and NUM_PORTS*64: per-port destination, tag and payload.
REQ-009 SHALL have port rcv_rdy_i, input, NUM_PORTS: per-port receive ready, driven by the unit's bus_rdy_o.
REQ-010 SHALL have port rcv_val_o, output, NUM_PORTS: per-port delivery valid, driving the unit's bus_val_i.
REQ-011 SHALL have ports rcv_src_o, rcv_tag_o and rcv_msg_o, output, 32, 32 and 64: delivered source, tag and payload, shared by all ports.
REQ-012 SHALL have port busy_o, output, 1: high while a message is held (DELIVER state).
REQ-013 SHALL have port drop_count_o, output, DROP_COUNT_WIDTH: saturating count of undeliverable messages.

Function
REQ-014 SHALL implement the FSM states IDLE and DELIVER.
REQ-015 SHALL, in IDLE with any snd_val_i set, grant one port round-robin, searching upward from last_grant+1 with wrap modulo NUM_PORTS.
REQ-016 SHALL, in the grant cycle, drive snd_ack_o[g]=1 for exactly that cycle.
REQ-017 SHALL, in the grant cycle, latch the message register from port g: src=port_address_i[g], dst, tag and msg.
REQ-018 SHALL, in the grant cycle, set last_grant=g and move to DELIVER.
REQ-019 SHALL hold snd_ack_o at 0 in DELIVER, so no new message is accepted while one is held.
REQ-020 SHALL assume each sender holds val, dst, tag and msg stable until acked; this is the sender's obligation and is asserted by the bench.
REQ-021 SHALL, in DELIVER, compute the target as the lowest index i with port_address_i[i]==dst; equality is on all 32 bits.
REQ-022 SHALL, in DELIVER with a target found, drive rcv_val_o to one-hot on the target, with all other bits 0.
REQ-023 SHALL hold rcv_val_o and the rcv_* data stable until rcv_rdy_i[target]=1, then return to IDLE on the next edge.
REQ-024 SHALL accept delivery in the same cycle rcv_rdy_i rises; rcv_rdy_i of non-target ports is ignored.
REQ-025 SHALL, in DELIVER with no address match, keep rcv_val_o=0 and return to IDLE after exactly one DELIVER cycle.
REQ-026 SHALL, on an unmatched message, increment drop_count_o by 1, saturating at all-ones.
REQ-027 SHALL allow self-delivery (dst equal to the sender's own address) and treat it as a normal delivery.
REQ-028 SHALL drive rcv_src_o, rcv_tag_o and rcv_msg_o from the message register at all times; they are don't-care when rcv_val_o=0.
REQ-029 SHALL give a minimum per-message latency of 2 cycles (grant, then deliver) and a peak throughput of 1 message per 2 cycles.
REQ-030 SHALL NOT decode flush; once acked, a message is committed to delivery.

Reset
REQ-031 SHALL, with rst=1 at a rising edge, return the FSM to IDLE and discard any held message even mid-DELIVER.
REQ-032 SHALL, on reset, set last_grant=NUM_PORTS-1 so that port 0 wins the first arbitration.
REQ-033 SHALL, on reset, clear the message register and the drop counter to 0.
REQ-034 SHALL drive snd_ack_o=0, rcv_val_o=0, busy_o=0 and drop_count_o=0 during and immediately after reset.
REQ-035 SHALL not ack any sender in a cycle where rst=1.

Verification
REQ-036 SHALL cover single transfer: port 1 sends dst=addr[2], tag=0x5, msg=0xDEADBEEF, and rcv_rdy_i[2]=1 -> ack[1] on cycle 0; rcv_val_o=4'b0100 on cycle 1 with src=addr[1]; IDLE on cycle 2.
REQ-037 SHALL cover fairness: all four ports hold val continuously after reset -> grants in order 0,1,2,3,0 on every other cycle, with no port acked twice before the others.
REQ-038 SHALL cover back-pressure: rcv_rdy_i[3]=0 for 5 cycles -> rcv_val_o[3] held with stable data and busy_o=1 throughout, and no acks issued; delivery occurs the cycle rdy rises.
REQ-039 SHALL cover drop: dst matches no port -> rcv_val_o stays 0 and drop_count_o goes 0->1; then force the counter to all-ones minus 1 and drop 2 more -> count saturates at 0xFFFF.
REQ-040 SHALL cover mid-delivery reset: rst=1 while DELIVER with rdy=0 -> next cycle rcv_val_o=0 and busy_o=0, and the first grant after reset goes to port 0.
REQ-041 SHALL cover duplicate addresses: ports 1 and 3 both hold dst's address -> delivery to port 1 only.
